booth4_seq_mult: RTL and testbench

//   Iterative signed multiplier controller that sequences one radix-4 Booth digit per clock.

---
 rtl/booth4_seq_mult_if.sv | 36 +++
 rtl/booth4_seq_mult.sv | 134 +++++++++++++
 tb/tb_booth4_seq_mult.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/booth4_seq_mult_if.sv
// -----------------------------------------------------------------------------
// booth4_seq_mult_if
//   Operand/result handshake bundle for the sequential radix-4 Booth multiplier.
//   slave  : the multiplier side (accepts operands, produces the product)
//   master : the producer/consumer side (drives operands, accepts the product)
// Signals
//   valid_i   operand pair on a_i/b_i is valid
//   ready_o   multiplier can accept operands
//   a_i, b_i  two's-complement multiplicand / multiplier, LENGTH bits
//   valid_o   product_o holds a completed result
//   ready_i   consumer accepts product_o
//   product_o signed product, 2*LENGTH bits
//   busy_o    a multiplication is in progress or waiting to be collected
// -----------------------------------------------------------------------------
interface booth4_seq_mult_if #(
    parameter int LENGTH = 8
);
    logic                  valid_i;
    logic                  ready_o;
    logic [LENGTH-1:0]     a_i;
    logic [LENGTH-1:0]     b_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [2*LENGTH-1:0]   product_o;
    logic                  busy_o;

    modport slave (
        input  valid_i, a_i, b_i, ready_i,
        output ready_o, valid_o, product_o, busy_o
    );

    modport master (
        output valid_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, product_o, busy_o
    );
endinterface

// File: rtl/booth4_seq_mult.sv
// -----------------------------------------------------------------------------
// booth4_seq_mult
//   Iterative signed multiplier retiring one radix-4 Booth digit per clock.
//   One multiplication in flight; returns the exact 2*LENGTH-bit product.
// Ports
//   clk_i    clock, rising edge
//   rst_n_i  synchronous active-low reset
//   bus      booth4_seq_mult_if.slave: operand handshake (valid_i/ready_o,
//            a_i, b_i), result handshake (valid_o/ready_i, product_o), busy_o
// Parameters
//   LENGTH   operand width, even and >= 4
// -----------------------------------------------------------------------------
module booth4_seq_mult #(
    parameter int LENGTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    booth4_seq_mult_if.slave        bus
);
    localparam int HALF = LENGTH / 2;
    localparam int CW   = $clog2(HALF + 1);
    localparam int AW   = LENGTH + 2;    // holds +-2*A without overflow

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_next;
    logic [AW-1:0]     a_reg;            // sign-extended multiplicand
    logic [LENGTH:0]   b_reg;            // multiplier with implicit b[-1]=0 in bit 0
    logic [AW-1:0]     acc_hi;           // upper accumulator, weight 2^LENGTH
    logic [LENGTH-1:0] acc_lo;           // product bits shifted out of acc_hi
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     pp;
    logic [AW-1:0]     sum;
    logic [2*AW-3:0]   shifted;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_next;
    end

    // -------------------------------------------------------------------------
    // Next state and state-decoded handshake outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        bus.ready_o = 1'b0;
        bus.valid_o = 1'b0;
        bus.busy_o  = 1'b0;
        case (state)
            IDLE: begin
                bus.ready_o = 1'b1;
                if (bus.valid_i) state_next = CALC;
            end
            CALC: begin
                bus.busy_o = 1'b1;
                // Digit steps occupy cnt = 0..HALF-1; cnt == HALF is the
                // write-back cycle that registers the result into product_o.
                if (cnt == CW'(HALF)) state_next = DONE;
            end
            DONE: begin
                bus.busy_o  = 1'b1;
                bus.valid_o = 1'b1;
                if (bus.ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Booth digit decode: triplet {b[2i+1], b[2i], b[2i-1]} -> 0, +-A, +-2A
    // -------------------------------------------------------------------------
    always_comb begin
        pp = '0;
        case (b_reg[2:0])
            3'b001, 3'b010: pp = a_reg;
            3'b011:         pp = a_reg << 1;
            3'b100:         pp = -(a_reg << 1);
            3'b101, 3'b110: pp = -a_reg;
            default:        pp = '0;
        endcase
    end

    // Add the partial product at weight 2^LENGTH, then shift the whole
    // accumulator right arithmetically by 2. After HALF steps each digit has
    // landed at weight 4^i and {acc_hi, acc_lo} equals A*B exactly.
    always_comb begin
        sum     = acc_hi + pp;
        shifted = {{2{sum[AW-1]}}, sum, acc_lo[LENGTH-1:2]};
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            a_reg         <= '0;
            b_reg         <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            cnt           <= '0;
            bus.product_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_i) begin
                        a_reg  <= {{2{bus.a_i[LENGTH-1]}}, bus.a_i};
                        b_reg  <= {bus.b_i, 1'b0};
                        acc_hi <= '0;
                        acc_lo <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (cnt == CW'(HALF)) begin
                        bus.product_o <= {acc_hi[LENGTH-1:0], acc_lo};
                    end else begin
                        acc_hi <= shifted[2*AW-3:LENGTH];
                        acc_lo <= shifted[LENGTH-1:0];
                        b_reg  <= b_reg >> 2;
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth4_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_booth4_seq_mult
//   Self-checking bench for booth4_seq_mult (LENGTH=8): table of directed
//   vectors, stall/abort sequences, corner cross-product and random pairs.
//   Expected products go into a scoreboard queue when operands are driven and
//   are popped when valid_o is seen.
// -----------------------------------------------------------------------------
module tb_booth4_seq_mult;
    localparam int LENGTH = 8;
    localparam int HALF   = LENGTH / 2;
    localparam int PW     = 2 * LENGTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    booth4_seq_mult_if #(.LENGTH(LENGTH)) bus ();

    booth4_seq_mult #(.LENGTH(LENGTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LENGTH-1:0] a;
        logic [LENGTH-1:0] b;
        logic [PW-1:0]     prod;
    } vec_t;

    vec_t          vecs [10];
    logic [PW-1:0] sb [$];
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b);
        logic signed [PW-1:0] sa;
        logic signed [PW-1:0] sbv;
        sa  = PW'($signed(a));
        sbv = PW'($signed(b));
        return PW'(sa * sbv);
    endfunction

    // Wait for ready_o, present one operand pair for a single edge, then
    // scramble the operand inputs so later changes are shown to be ignored.
    task automatic send(input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b,
                        input logic [PW-1:0] exp, input bit keep);
        int n = 0;
        while (bus.ready_o !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_send", 64'(bus.ready_o), 64'd1);
        bus.valid_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        if (keep) sb.push_back(exp);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.a_i     = LENGTH'($urandom);
        bus.b_i     = LENGTH'($urandom);
        check("busy_after_accept", 64'(bus.busy_o), 64'd1);
    endtask

    // Count cycles from acceptance until valid_o; bounded.
    task automatic wait_valid();
        int lat = 0;
        while (bus.valid_o !== 1'b1 && lat < 4 * LENGTH) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", 64'(lat), 64'(HALF + 1));
    endtask

    // Compare the product against the scoreboard, then complete the handshake.
    task automatic collect();
        logic [PW-1:0] exp;
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
            return;
        end
        exp = sb.pop_front();
        check("product", 64'(bus.product_o), 64'(exp));
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        check("valid_after_handshake", 64'(bus.valid_o), 64'd0);
        check("ready_after_handshake", 64'(bus.ready_o), 64'd1);
        check("product_held", 64'(bus.product_o), 64'(exp));
    endtask

    task automatic run_op(input logic [LENGTH-1:0] a, input logic [LENGTH-1:0] b, input logic [PW-1:0] exp);
        send(a, b, exp, 1'b1);
        wait_valid();
        collect();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [LENGTH-1:0] corners [5];
        bit                saw_valid;

        vecs[0] = '{8'h03, 8'h05, 16'h000F};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h80, 8'h7F, 16'hC080};
        vecs[3] = '{8'hFF, 8'h01, 16'hFFFF};
        vecs[4] = '{8'h00, 8'hB3, 16'h0000};
        vecs[5] = '{8'h7F, 8'hFF, 16'hFF81};
        vecs[6] = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[7] = '{8'h80, 8'h01, 16'hFF80};
        vecs[8] = '{8'hAA, 8'h55, 16'hE372};
        vecs[9] = '{8'h02, 8'hFD, 16'hFFFA};
        corners = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01};

        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.a_i     = '0;
        bus.b_i     = '0;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_ready", 64'(bus.ready_o), 64'd1);
        check("reset_valid", 64'(bus.valid_o), 64'd0);
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_product", 64'(bus.product_o), 64'd0);

        // Directed table
        for (int i = 0; i < 10; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].prod);

        // Consumer stall for 10 cycles while inputs toggle
        bus.ready_i = 1'b0;
        send(8'd12, 8'd11, 16'd132, 1'b1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            bus.valid_i = 1'($urandom);
            bus.a_i     = LENGTH'($urandom);
            bus.b_i     = LENGTH'($urandom);
            @(posedge clk); #1;
            check("stall_product", 64'(bus.product_o), 64'd132);
            check("stall_valid", 64'(bus.valid_o), 64'd1);
            check("stall_ready", 64'(bus.ready_o), 64'd0);
        end
        bus.valid_i = 1'b0;
        collect();
        check("idle_busy", 64'(bus.busy_o), 64'd0);
        @(posedge clk); #1;
        check("nothing_accepted", 64'(bus.busy_o), 64'd0);

        // Reset during the third CALC cycle aborts the operation
        send(8'd9, 8'd9, 16'd81, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_ready", 64'(bus.ready_o), 64'd1);
        check("abort_busy", 64'(bus.busy_o), 64'd0);
        check("abort_product", 64'(bus.product_o), 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.valid_o === 1'b1) saw_valid = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_valid", 64'(saw_valid), 64'd0);
        run_op(8'd6, 8'd7, 16'h002A);

        // Corner cross-product
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                run_op(corners[i], corners[j], ref_mul(corners[i], corners[j]));

        // Random pairs, occasionally stalling the consumer
        for (int i = 0; i < 1500; i++) begin
            logic [LENGTH-1:0] a;
            logic [LENGTH-1:0] b;
            a = LENGTH'($urandom);
            b = LENGTH'($urandom);
            send(a, b, ref_mul(a, b), 1'b1);
            bus.ready_i = 1'($urandom_range(0, 3) != 0);
            wait_valid();
            if (!bus.ready_i) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            collect();
        end

        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
